// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
//
// Built-in self-test sequencer for a 32-word x 32-bit byte-sliced memory.
// During a test it owns the memory's write data, address and strobes. It runs
// a four-phase march and checks every read word against the expected value:
//   WR0 : write P(a)  to every address, ascending
//   RD0 : read every address, ascending, compare against P(a)
//   WR1 : write ~P(a) to every address, ascending
//   RD1 : read every address, ascending, compare against ~P(a)
// The test pattern byte lane k of P(a) is {k[1:0], 1'b1, a[4:0]}. Each byte
// therefore carries both the address and its own lane number, which exposes
// address aliasing and lane swaps.
//
// The memory returns read data one cycle after mem_read_en. The compare for a
// read therefore runs in the following cycle against a registered copy of the
// read address. Each read phase ends with one drain cycle that issues no
// strobe and only completes the last compare.
//
// Ports
//   clock         rising-edge clock, shared with the memory
//   reset         asynchronous, active-high; clears all state and outputs
//   start         launch request; only sampled in IDLE or DONE
//   mem_data_out  memory read data, valid one cycle after mem_read_en
//   mem_data_in   write data to the memory
//   mem_address   memory address
//   mem_write_en  memory write strobe
//   mem_read_en   memory read strobe
//   busy          high from start acceptance until DONE is entered
//   done          high in DONE; held until the next start or reset
//   pass          done with no mismatches recorded
//   err_count     number of mismatching words, saturating at 63
//   fail_phase    read phase of the first mismatch (0 = RD0, 1 = RD1)
//   fail_addr     address of the first mismatch
//   fail_data     read data captured at the first mismatch
// -----------------------------------------------------------------------------
module mem_bist_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [5:0]        err_count,
    output logic              fail_phase,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR0  = 3'd1;
    localparam logic [2:0] S_RD0  = 3'd2;
    localparam logic [2:0] S_WR1  = 3'd3;
    localparam logic [2:0] S_RD1  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [5:0]        ERR_MAX   = 6'd63;

    // Byte lane k of the pattern is {k[1:0], 1'b1, a[4:0]}.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        logic [4:0]        a5;
        a5 = 5'(a);
        p  = '0;
        for (int k = 0; k < DATA_W / 8; k++) begin
            p[8*k +: 8] = {2'(k), 1'b1, a5};
        end
        return p;
    endfunction

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              drain;       // set during the post-read drain cycle
    logic              drain_nx;
    logic              launch;

    // Compare pipeline: describes the read issued in the previous cycle.
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_inv;     // 1 when the read belongs to RD1
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    // NOTE: every signal assigned in this block gets a default value first, so
    // no path through the case statement can leave one unassigned and infer a
    // latch.
    always_comb begin
        state_nx = state;
        addr_nx  = mem_address;
        drain_nx = drain;
        launch   = 1'b0;
        exp_data = pattern(cmp_addr) ^ {DATA_W{cmp_inv}};
        mismatch = cmp_valid && (mem_data_out != exp_data);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch   = 1'b1;
                    state_nx = S_WR0;
                    addr_nx  = '0;
                    drain_nx = 1'b0;
                end
            end

            S_WR0, S_WR1: begin
                if (mem_address == ADDR_LAST) begin
                    state_nx = (state == S_WR0) ? S_RD0 : S_RD1;
                    addr_nx  = '0;
                end else begin
                    addr_nx = mem_address + 1'b1;
                end
            end

            S_RD0, S_RD1: begin
                if (drain) begin
                    state_nx = (state == S_RD0) ? S_WR1 : S_DONE;
                    addr_nx  = '0;
                    drain_nx = 1'b0;
                end else if (mem_address == ADDR_LAST) begin
                    // Hold the address; the next cycle only finishes the
                    // compare of the last read.
                    drain_nx = 1'b1;
                end else begin
                    addr_nx = mem_address + 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
                addr_nx  = '0;
                drain_nx = 1'b0;
            end
        endcase

        // Abort on the first mismatch. The only mismatch ever registered is
        // the first one, because the FSM leaves the read phase on that edge.
        if (STOP_ON_FAIL && mismatch) begin
            state_nx = S_DONE;
            addr_nx  = '0;
            drain_nx = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            drain        <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmp_valid    <= 1'b0;
            cmp_addr     <= '0;
            cmp_inv      <= 1'b0;
            err_count    <= '0;
            fail_phase   <= 1'b0;
            fail_addr    <= '0;
            fail_data    <= '0;
        end else begin
            state        <= state_nx;
            drain        <= drain_nx;
            mem_address  <= addr_nx;

            // Strobes and write data are decoded from the next state, so they
            // come straight out of flops and line up with the new address.
            mem_write_en <= (state_nx == S_WR0) || (state_nx == S_WR1);
            mem_read_en  <= ((state_nx == S_RD0) || (state_nx == S_RD1)) && !drain_nx;
            if (state_nx == S_WR0) begin
                mem_data_in <= pattern(addr_nx);
            end else if (state_nx == S_WR1) begin
                mem_data_in <= ~pattern(addr_nx);
            end else begin
                mem_data_in <= '0;
            end

            busy <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done <= (state_nx == S_DONE);

            // A read issued this cycle is compared next cycle, unless the FSM
            // is aborting, in which case its data is never looked at.
            cmp_valid <= mem_read_en && (state_nx != S_DONE);
            cmp_addr  <= mem_address;
            cmp_inv   <= (state == S_RD1);

            if (launch) begin
                err_count  <= '0;
                fail_phase <= 1'b0;
                fail_addr  <= '0;
                fail_data  <= '0;
            end else if (mismatch) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 1'b1;
                end
                // err_count never returns to zero within a run, so zero means
                // this is the first mismatch since start.
                if (err_count == '0) begin
                    fail_phase <= cmp_inv;
                    fail_addr  <= cmp_addr;
                    fail_data  <= mem_data_out;
                end
            end
        end
    end

    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bist_ctrl
//
// Two controller instances (run-all and stop-on-fail), each attached to a
// behavioural 32x32 memory with a configurable read-path fault. For every run
// a reference model walks the march at the word level, predicts the results,
// and the bench compares them with what the controller reports.
// -----------------------------------------------------------------------------
module tb_mem_bist_ctrl;

    logic        clock;
    logic        reset;
    logic        start_a, start_b;

    logic [31:0] a_dout, a_din, a_fdata;
    logic [4:0]  a_addr, a_faddr;
    logic        a_we, a_re, a_busy, a_done, a_pass, a_fphase;
    logic [5:0]  a_err;

    logic [31:0] b_dout, b_din, b_fdata;
    logic [4:0]  b_addr, b_faddr;
    logic        b_we, b_re, b_busy, b_done, b_pass, b_fphase;
    logic [5:0]  b_err;

    int checks = 0;
    int errors = 0;

    // Fault configuration applied on the memory read path.
    bit zero_all  = 1'b0;
    bit fault_en  = 1'b0;
    bit fault_col = 1'b0;   // 1: fault hits every address
    int f_addr    = 0;
    int f_bit     = 0;
    bit f_val     = 1'b0;

    mem_bist_ctrl #(.ADDR_W(5), .DATA_W(32), .STOP_ON_FAIL(1'b0)) u_dut (
        .clock(clock), .reset(reset), .start(start_a),
        .mem_data_out(a_dout), .mem_data_in(a_din), .mem_address(a_addr),
        .mem_write_en(a_we), .mem_read_en(a_re),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .fail_phase(a_fphase), .fail_addr(a_faddr), .fail_data(a_fdata)
    );

    mem_bist_ctrl #(.ADDR_W(5), .DATA_W(32), .STOP_ON_FAIL(1'b1)) u_stop (
        .clock(clock), .reset(reset), .start(start_b),
        .mem_data_out(b_dout), .mem_data_in(b_din), .mem_address(b_addr),
        .mem_write_en(b_we), .mem_read_en(b_re),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
        .fail_phase(b_fphase), .fail_addr(b_faddr), .fail_data(b_fdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected pattern built arithmetically: lane k holds k*64 + 32 + a.
    function automatic logic [31:0] pat(input int a);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < 4; k++) v = v + (32'(k * 64 + 32 + a) << (8 * k));
        return v;
    endfunction

    function automatic logic [31:0] corrupt(input int a, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (zero_all) r = 32'd0;
        else if (fault_en && (fault_col || a == f_addr)) r[f_bit] = f_val;
        return r;
    endfunction

    // Behavioural memories plus strobe monitors (counters only ever grow).
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, ovl = 0;

    always @(posedge clock) begin
        if (a_we) begin mem_a[a_addr] <= a_din; wr_a <= wr_a + 1; end
        if (a_re) begin a_dout <= corrupt(int'(a_addr), mem_a[a_addr]); rd_a <= rd_a + 1; end
        if (b_we) begin mem_b[b_addr] <= b_din; wr_b <= wr_b + 1; end
        if (b_re) begin b_dout <= corrupt(int'(b_addr), mem_b[b_addr]); rd_b <= rd_b + 1; end
        if ((a_we && a_re) || (b_we && b_re)) ovl <= ovl + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Word-level reference of the march: what each compare sees, in order.
    task automatic ref_model(input bit stop, output int e_err, output int e_phase,
                             output int e_addr, output logic [31:0] e_data,
                             output int e_lat, output int e_rd, output int e_wr);
        bit found, stopped;
        logic [31:0] good, seen;
        e_err = 0; e_phase = 0; e_addr = 0; e_data = 32'd0;
        e_lat = 130; e_rd = 64; e_wr = 64;
        found = 1'b0; stopped = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 32; a++) begin
                if (!stopped) begin
                    good = (p == 0) ? pat(a) : ~pat(a);
                    seen = corrupt(a, good);
                    if (seen != good) begin
                        if (e_err < 63) e_err++;
                        if (!found) begin
                            found = 1'b1;
                            e_phase = p; e_addr = a; e_data = seen;
                            if (stop) begin
                                stopped = 1'b1;
                                // Read of a issued 32+65p+a edges after start,
                                // its compare registers two edges later.
                                e_lat = 32 + 65 * p + a + 2;
                                e_wr  = 32 * (p + 1);
                                e_rd  = 32 * p + ((a + 2 > 32) ? 32 : a + 2);
                            end
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic obs_busy(input bit s); return s ? b_busy : a_busy; endfunction
    function automatic logic obs_done(input bit s); return s ? b_done : a_done; endfunction

    // One full run: start pulse, optional re-pulse at cycle repulse_k, then
    // compare everything against the reference model.
    task automatic do_run(input string tag, input bit use_stop, input int repulse_k);
        int e_err, e_phase, e_addr, e_lat, e_rd, e_wr;
        logic [31:0] e_data;
        int lat, busy_cyc, wr0, rd0, ov0;
        ref_model(use_stop, e_err, e_phase, e_addr, e_data, e_lat, e_rd, e_wr);
        @(negedge clock);
        wr0 = use_stop ? wr_b : wr_a;
        rd0 = use_stop ? rd_b : rd_a;
        ov0 = ovl;
        if (use_stop) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clock);                     // just after the launch edge E0
        start_a = 1'b0; start_b = 1'b0;
        lat = -1;
        busy_cyc = obs_busy(use_stop) ? 1 : 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);                 // just after edge E0+k
            if (k == repulse_k) begin
                if (use_stop) start_b = 1'b1; else start_a = 1'b1;
            end else if (k == repulse_k + 1) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (obs_done(use_stop)) begin lat = k; break; end
            if (obs_busy(use_stop)) busy_cyc++;
        end
        start_a = 1'b0; start_b = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check({tag, ".busy_cycles"}, 32'(busy_cyc), 32'(e_lat));
        check({tag, ".busy_at_done"}, 32'(obs_busy(use_stop)), 32'd0);
        repeat (3) @(negedge clock);          // strobes must stay quiet in DONE
        if (use_stop) begin
            check({tag, ".done"}, 32'(b_done), 32'd1);
            check({tag, ".pass"}, 32'(b_pass), 32'(e_err == 0));
            check({tag, ".err_count"}, 32'(b_err), 32'(e_err));
            check({tag, ".fail_phase"}, 32'(b_fphase), 32'(e_phase));
            check({tag, ".fail_addr"}, 32'(b_faddr), 32'(e_addr));
            check({tag, ".fail_data"}, b_fdata, e_data);
            check({tag, ".writes"}, 32'(wr_b - wr0), 32'(e_wr));
            check({tag, ".reads"}, 32'(rd_b - rd0), 32'(e_rd));
        end else begin
            check({tag, ".done"}, 32'(a_done), 32'd1);
            check({tag, ".pass"}, 32'(a_pass), 32'(e_err == 0));
            check({tag, ".err_count"}, 32'(a_err), 32'(e_err));
            check({tag, ".fail_phase"}, 32'(a_fphase), 32'(e_phase));
            check({tag, ".fail_addr"}, 32'(a_faddr), 32'(e_addr));
            check({tag, ".fail_data"}, a_fdata, e_data);
            check({tag, ".writes"}, 32'(wr_a - wr0), 32'(e_wr));
            check({tag, ".reads"}, 32'(rd_a - rd0), 32'(e_rd));
        end
        check({tag, ".strobe_overlap"}, 32'(ovl - ov0), 32'd0);
    endtask

    task automatic set_fault(input bit en, input bit col, input int addr,
                             input int bitpos, input bit val, input bit zero);
        fault_en = en; fault_col = col; f_addr = addr;
        f_bit = bitpos; f_val = val; zero_all = zero;
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(negedge clock);
        check("reset.busy", 32'(a_busy), 32'd0);
        check("reset.done", 32'(a_done), 32'd0);
        check("reset.pass", 32'(a_pass), 32'd0);
        check("reset.strobes", 32'({a_we, a_re, b_we, b_re}), 32'd0);
        check("reset.err_count", 32'(a_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Fault-free run on both controllers.
        set_fault(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        do_run("clean", 1'b0, -10);
        do_run("clean_stop", 1'b1, -10);

        // Bit 7 stuck at 0 at address 5: only the inverse read can see it.
        set_fault(1'b1, 1'b0, 5, 7, 1'b0, 1'b0);
        do_run("addr5_bit7", 1'b0, -10);
        check("addr5_bit7.fail_data_const", a_fdata, 32'h1A5A9A5A);

        // Memory returns zero: 64 mismatches, counter saturates.
        set_fault(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        do_run("all_zero", 1'b0, -10);
        check("all_zero.err_sat", 32'(a_err), 32'd63);

        // Stop-on-fail with bit 0 stuck at 0 at address 3 (fails in RD0).
        set_fault(1'b1, 1'b0, 3, 0, 1'b0, 1'b0);
        do_run("stop_addr3", 1'b1, -10);

        // Start re-pulsed in the middle of WR1 must be ignored.
        set_fault(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        do_run("repulse_wr1", 1'b0, 80);

        // Reset in the middle of RD0, with one mismatch already recorded.
        set_fault(1'b1, 1'b0, 2, 5, 1'b0, 1'b0);
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        repeat (40) @(negedge clock);
        check("midrd0.read_en", 32'(a_re), 32'd1);
        check("midrd0.err_count", 32'(a_err), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrd0.strobes_async", 32'({a_we, a_re}), 32'd0);
        check("midrd0.outputs", 32'({a_busy, a_done, a_pass, a_fphase}), 32'd0);
        check("midrd0.err_cleared", 32'(a_err), 32'd0);
        check("midrd0.fail_addr", 32'(a_faddr), 32'd0);
        check("midrd0.fail_data", a_fdata, 32'd0);
        check("midrd0.address", 32'(a_addr), 32'd0);
        check("midrd0.data_in", a_din, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        set_fault(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        do_run("after_reset", 1'b0, -10);

        // Randomised single-cell and column stuck-at faults on both flavours.
        for (int i = 0; i < 10; i++) begin
            set_fault(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
            do_run($sformatf("rand%0d", i), 1'(i % 2), -10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
Built-in self-test sequencer for the 32-word x 32-bit byte-sliced memory. It sits directly upstream of the memory and owns its data_in/address/read_en/write_en during test. It also consumes the memory's data_out and checks it. It runs a four-phase march (write pattern, read/compare, write inverse, read/compare) and reports pass/fail, an error count and first-failure capture.

Parameters:
ADDR_W, 5, memory address width; depth = 2**ADDR_W words (32).
DATA_W, 32, memory word width; four 8-bit byte lanes, fixed at 32.
STOP_ON_FAIL, 0, 1 = abort to DONE on the first mismatch; 0 = run all phases.

Ports:
clock  input  1  rising-edge clock, shared with memory.
reset  input  1  asynchronous, active-high; clears all state and outputs.
start  input  1  pulse/level; sampled only in IDLE or DONE.
mem_data_out  input  32  memory read data; valid 1 cycle after mem_read_en.
mem_data_in  output  32  write data to memory.
mem_address  output  5  memory address.
mem_write_en  output  1  memory write strobe.
mem_read_en  output  1  memory read strobe.
busy  output  1  high from start acceptance until DONE entered.
done  output  1  high in DONE; held until next start or reset.
pass  output  1  done && err_count==0.
err_count  output  6  mismatching words, saturates at 63.
fail_phase  output  1  phase of first mismatch: 0 = RD0, 1 = RD1.
fail_addr  output  5  address of first mismatch.
fail_data  output  32  mem_data_out captured at first mismatch.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; mem_write_en and mem_read_en drop immediately, not at the next edge.
- Pattern: P(a) byte lane k (k=0..3) = {k[1:0], 1'b1, a[4:0]}; for example, P(5)=0xE5A56525. Inverse pattern = ~P(a).
- States: IDLE, WR0, RD0, WR1, RD1, DONE.
- IDLE/DONE to WR0: on start=1 at a clock edge. The entry edge clears err_count, the fail_* outputs and done. It also sets busy and sets address to 0.
- WR0: one write per cycle; mem_write_en=1, mem_data_in=P(addr), address 0 to 31 ascending. After addr 31, go to RD0 with address 0.
- RD0: mem_read_en=1, address 0 to 31 ascending, one per cycle. Data for the read issued in cycle n is compared in cycle n+1 against a registered expected address.
  - After the read of addr 31 comes one drain cycle: no strobes, final compare only.
  - Then go to WR1.
- WR1: as WR0, writing ~P(addr). Then RD1: as RD0, comparing against ~P. Then the drain cycle, then DONE.
- Strobes: mem_read_en and mem_write_en are never high in the same cycle. Both are low in IDLE, DONE and drain cycles.
- Mismatch:
  - err_count increments, saturating at 63.
  - If this is the first mismatch since start, capture fail_phase, fail_addr and fail_data on the same edge.
  - Later mismatches do not alter the fail_* outputs.
- STOP_ON_FAIL=1: the edge that registers the first mismatch moves the FSM to DONE. No further strobes are issued.
- Latency: start accepted at edge E0; done rises at edge E0+130 (32+33+32+33). busy falls on that same edge.
- start while busy: ignored. start held high in DONE: re-launches on the next edge.
- Address counter: wraps 31 to 0 only at phase transitions; it never wraps inside a phase.
- Outputs are registered. pass is combinational from done and err_count.

Test Plan:
- Fault-free memory model, start pulse at cycle 0 -> busy for 130 cycles, done=1, pass=1, err_count=0. Check strobe counts: 64 writes, 64 reads.
- Model forces data_out bit7=0 at addr 5 -> RD1 mismatch only. Expect err_count=1, fail_phase=1, fail_addr=5, fail_data=0x1A5A9A5A, pass=0.
- Model returns data_out=0 always -> all 64 compares fail. Expect err_count=63 (saturated), fail_phase=0, fail_addr=0, fail_data=0x00000000.
- STOP_ON_FAIL=1 with a stuck fault at RD0 addr 3 -> done asserts 1 cycle after the addr-3 compare. No strobes after that; err_count=1.
- start re-pulsed mid-WR1 -> ignored; the run completes at the original E0+130.
- reset asserted mid-RD0 -> strobes drop asynchronously and all outputs go to 0. A new start then runs a clean full test that passes.
